trng_word_packer: RTL and testbench

TRNG_WORD_PACKER -- requirements
Module: trng_word_packer

---
 rtl/trng_word_packer.sv | 154 +++++++++++++++
 tb/tb_trng_word_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_word_packer.sv
// Packs debiased TRNG bits MSB-first into words and buffers them in a FWFT FIFO.
// Optional repetition-count health test is compiled in with `define TRNG_REPCOUNT_EN.
module trng_word_packer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RC_CUTOFF  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bit_in,
  input  logic                              bit_valid,
  input  logic                              word_ready,
  input  logic                              overflow_clr,
  output logic [WORD_W-1:0]                 word_out,
  output logic                              word_valid,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow,
  output logic                              health_fail
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W);

  if (WORD_W < 2 || WORD_W > 32 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RC_CUTOFF < 2 || RC_CUTOFF > 255) begin : g_bad_cfg
    $error("trng_word_packer: parameter out of range");
  end

  typedef enum logic {
    FILL = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   sr;
  logic [CW-1:0]       cnt;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [LW-1:0]       level;

  logic                accept;
  logic                rc_hit;
  logic                shift_en;
  logic                word_done;
  logic                pop;
  logic                push;
  logic                drop;
  logic [WORD_W-1:0]   word_next;

  assign accept    = bit_valid && (state == FILL);
  assign shift_en  = accept && !rc_hit;
  assign word_next = {sr[WORD_W-2:0], bit_in};
  assign word_done = shift_en && (cnt == CW'(WORD_W - 1));

  assign word_valid = (level != '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_level = level;
  assign word_out   = word_valid ? mem[rd_ptr] : '0;

  // A full FIFO can still take a word when the head leaves on the same edge.
  assign pop  = word_valid && word_ready;
  assign push = word_done && (!fifo_full || pop);
  assign drop = word_done && fifo_full && !pop;

`ifdef TRNG_REPCOUNT_EN
  logic [7:0] run_cnt;
  logic [7:0] run_next;
  logic       last_bit;
  logic       hf;

  always_comb begin
    run_next = run_cnt;
    if (run_cnt == 8'd0 || bit_in != last_bit) begin
      run_next = 8'd1;
    end else if (run_cnt < 8'(RC_CUTOFF)) begin
      run_next = run_cnt + 8'd1;
    end
  end

  assign rc_hit      = accept && (run_next == 8'(RC_CUTOFF));
  assign health_fail = hf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      last_bit <= 1'b0;
      hf       <= 1'b0;
    end else if (accept) begin
      run_cnt  <= run_next;
      last_bit <= bit_in;
      if (rc_hit) begin
        hf <= 1'b1;
      end
    end
  end
`else
  assign rc_hit      = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      sr       <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (rc_hit) begin
        state <= HALT;
      end

      if (shift_en) begin
        if (word_done) begin
          cnt <= '0;
          sr  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
          sr  <= word_next;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= word_next;
    end
  end

endmodule

// File: tb/tb_trng_word_packer.sv
// Directed self-checking bench for trng_word_packer (WORD_W=8, FIFO_DEPTH=4, RC_CUTOFF=32).
module tb_trng_word_packer;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       word_ready;
  logic       overflow_clr;
  logic [7:0] word_out;
  logic       word_valid;
  logic       fifo_full;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       health_fail;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  trng_word_packer #(
    .WORD_W    (8),
    .FIFO_DEPTH(4),
    .RC_CUTOFF (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .word_ready  (word_ready),
    .overflow_clr(overflow_clr),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One accepted bit per call; back-to-back calls give consecutive valid edges.
  task automatic send_bit(input logic b, input logic with_ready, input logic gap);
    @(negedge clk);
    bit_in     = b;
    bit_valid  = 1'b1;
    word_ready = with_ready;
    @(posedge clk);
    #1;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic last_ready, input logic gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], (i == 0) ? last_ready : 1'b0, gap);
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd1);
    check(tag, {24'd0, word_out}, {24'd0, exp});
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    check({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
    check({tag, "_full"},  {31'd0, fifo_full},  32'd0);
    check({tag, "_word"},  {24'd0, word_out},   32'd0);
    check({tag, "_ovf"},   {31'd0, overflow},   32'd0);
    check({tag, "_hf"},    {31'd0, health_fail}, 32'd0);
  endtask

  logic [7:0] pat_a [5];
  logic [7:0] pat_b [5];
  logic [7:0] b2;

  initial begin
    rst          = 1'b1;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    word_ready   = 1'b0;
    overflow_clr = 1'b0;
    pat_a = '{8'hA1, 8'h5C, 8'h3E, 8'hC7, 8'h69};
    pat_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    b2    = 8'hB2;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Consecutive valid bits, MSB-first
    for (int i = 7; i >= 1; i--) send_bit(b2[i], 1'b0, 1'b0);
    check("b2_pre_valid", {31'd0, word_valid}, 32'd0);
    send_bit(b2[0], 1'b0, 1'b0);
    check("b2_valid", {31'd0, word_valid}, 32'd1);
    check("b2_word", {24'd0, word_out}, 32'hB2);
    check("b2_level", {29'd0, fifo_level}, 32'd1);
    pop_check("b2_pop", 8'hB2);
    check("b2_empty", {29'd0, fifo_level}, 32'd0);

    // Same bits with idle cycles in between
    send_word(8'hB2, 1'b0, 1'b1);
    check("gap_word", {24'd0, word_out}, 32'hB2);
    check("gap_level", {29'd0, fifo_level}, 32'd1);
    pop_check("gap_pop", 8'hB2);
    check("gap_empty", {29'd0, fifo_level}, 32'd0);

    // word_ready on an empty FIFO must not change anything
    @(negedge clk);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    check("empty_pop_level", {29'd0, fifo_level}, 32'd0);
    check("empty_pop_valid", {31'd0, word_valid}, 32'd0);

    // Overflow: five words into a four-deep FIFO
    for (int k = 0; k < 5; k++) begin
      send_word(pat_a[k], 1'b0, 1'b0);
      if (k == 3) check("ovf_pre", {31'd0, overflow}, 32'd0);
    end
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_full", {31'd0, fifo_full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    for (int k = 0; k < 4; k++) pop_check("ovf_drain", pat_a[k]);
    check("ovf_drained", {31'd0, word_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(posedge clk);
    #1;
    overflow_clr = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // Full FIFO with push and pop on the same edge
    for (int k = 0; k < 4; k++) send_word(pat_b[k], 1'b0, 1'b0);
    check("sim_full_pre", {31'd0, fifo_full}, 32'd1);
    send_word(pat_b[4], 1'b1, 1'b0);
    check("sim_level", {29'd0, fifo_level}, 32'd4);
    check("sim_full", {31'd0, fifo_full}, 32'd1);
    check("sim_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 1; k < 5; k++) pop_check("sim_drain", pat_b[k]);
    check("sim_empty", {29'd0, fifo_level}, 32'd0);

    // Reset mid-word with a word already buffered
    send_word(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    send_word(8'hF0, 1'b0, 1'b0);
    check("post_rst_level", {29'd0, fifo_level}, 32'd1);
    check("post_rst_word", {24'd0, word_out}, 32'hF0);
    pop_check("post_rst_pop", 8'hF0);

    // Long run of ones: health test behaviour
    for (int i = 0; i < 31; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("rc31_hf", {31'd0, health_fail}, 32'd0);
    check("rc31_level", {29'd0, fifo_level}, 32'd3);
    send_bit(1'b1, 1'b0, 1'b0);
`ifdef TRNG_REPCOUNT_EN
    check("rc32_hf", {31'd0, health_fail}, 32'd1);
    check("rc32_level", {29'd0, fifo_level}, 32'd3);
    for (int i = 0; i < 8; i++) send_bit(i[0], 1'b0, 1'b0);
    check("halt_level", {29'd0, fifo_level}, 32'd3);
    check("halt_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 3; k++) pop_check("halt_drain", 8'hFF);
    check("halt_empty", {31'd0, word_valid}, 32'd0);
    check("halt_hf_sticky", {31'd0, health_fail}, 32'd1);
`else
    check("rc32_hf", {31'd0, health_fail}, 32'd0);
    check("rc32_level", {29'd0, fifo_level}, 32'd4);
    check("rc32_full", {31'd0, fifo_full}, 32'd1);
    for (int k = 0; k < 4; k++) pop_check("rc_drain", 8'hFF);
    check("rc_empty", {31'd0, word_valid}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
